io_responder: RTL and testbench
===============================

Name: io_responder

Overview:
- Device-side end of the CPU's programmed-I/O handshake.
- Answers the CPU's input request (inp_req/inp_ack/inp_data) from an RX FIFO filled by an external producer.
- Accepts the CPU's output request (out_req/out_ack/out_data) into a TX FIFO drained by an external consumer.
- Sits between the CPU top level and the peripheral or testbench stream ports.

Parameters:
- WIDTH, 16, data word width; matches the CPU data bus.
- DEPTH, 4, entries per FIFO; power of two, at least 2.
- CW, $clog2(DEPTH)+1, occupancy counter width (derived localparam).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. One clock; reset is asynchronous and active-high.
- inp_req  in  1  CPU requests one input word; held high until inp_ack is seen.
- inp_ack  out  1  input word valid on inp_data; held until inp_req falls.
- inp_data  out  WIDTH  registered input word.
- out_req  in  1  CPU offers out_data; held high until out_ack is seen.
- out_data  in  WIDTH  word from the CPU; stable while out_req is high.
- out_ack  out  1  word captured; held until out_req falls.
- rx_valid  in  1  external producer has rx_data.
- rx_data  in  WIDTH  external input word.
- rx_ready  out  1  RX FIFO can accept; equals !rx_full.
- tx_valid  out  1  TX FIFO not empty.
- tx_data  out  WIDTH  TX FIFO head word (show-ahead).
- tx_ready  in  1  external consumer takes tx_data.
- rx_count  out  CW  RX occupancy.
- tx_count  out  CW  TX occupancy.

Behaviour:
- Reset (async, rst=1): both FSMs go to IDLE; inp_ack=0, out_ack=0, inp_data=0; both FIFOs empty; rx_count=tx_count=0; tx_valid=0; rx_ready=1. Reset mid-handshake aborts it; any in-flight word is lost.
- Handshake is four-phase: req rises, ack rises, req falls, ack falls. The responder never raises ack while req is low.
- Input FSM, states IDLE, ACK:
  - IDLE: if inp_req=1 and RX not empty, pop the head into inp_data, set inp_ack=1 at the next edge, go to ACK. Latency is 1 cycle from the sampled req.
  - IDLE with inp_req=1 and RX empty: wait, no ack.
  - ACK: inp_ack=1 and inp_data stable; when inp_req=0 is sampled, clear inp_ack and return to IDLE.
  - Exactly one pop per handshake.
- Output FSM, states IDLE, ACK:
  - IDLE: if out_req=1 and TX not full, push out_data, set out_ack=1 at the next edge, go to ACK.
  - IDLE with out_req=1 and TX full: stall, out_ack stays 0.
  - ACK: hold out_ack until out_req=0 is sampled, then return to IDLE. Exactly one push per handshake.
- External side:
  - RX push when rx_valid && rx_ready.
  - TX pop when tx_valid && tx_ready.
  - rx_data and tx_ready are ignored when the FIFO cannot act.
- Full/empty rules:
  - rx_ready is derived from the current-cycle full flag only. No push into a full FIFO, even when a pop happens in the same cycle.
  - No bypass: a word pushed in cycle N can be popped no earlier than cycle N+1.
  - Simultaneous push and pop on a non-full, non-empty FIFO: count unchanged, both occur.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Count ranges 0..DEPTH; full when count==DEPTH.
- Input and output channels are fully independent and may handshake in the same cycle.

Decomposition:
- Shared package (include file):
  - FSM state localparams: ST_IDLE=1'b0, ST_ACK=1'b1.
  - Default WIDTH and DEPTH.
- One sub-module, sync_fifo:
  - Parameters WIDTH and DEPTH.
  - Ports: push, push_data, pop, head_data, full, empty, count; async active-high reset.
  - Instantiated twice (RX, TX).
- The two handshake FSMs stay inline in io_responder.

Test Plan:
- Reset: assert rst mid-cycle with inp_req=1 -> inp_ack=0, out_ack=0, inp_data=0, rx_count=0, rx_ready=1 immediately (asynchronous).
- Input basic: push 16'hA5A5 via rx_valid; next cycle raise inp_req -> inp_ack=1 one cycle later with inp_data=16'hA5A5, rx_count=0; drop inp_req -> inp_ack=0 next cycle.
- Input empty stall: inp_req=1 with RX empty for 5 cycles -> inp_ack stays 0; push 16'h0042 -> inp_ack rises 2 cycles after the push with inp_data=16'h0042 (no bypass).
- Output full: tx_ready=0; four handshakes with 16'h0001..16'h0004 -> tx_count=4; fifth out_req -> out_ack stays 0; pulse tx_ready one cycle (tx_data=16'h0001 popped) -> fifth word acked on the following cycle.
- Ordering/wrap: 10 words 16'h0100..16'h0109 through RX with DEPTH=4 and interleaved CPU reads -> CPU receives them in order; pointers wrap with no loss or duplication.
- Concurrency: inp and out handshakes overlapping, with external push and pop in the same cycle on a half-full FIFO -> both acks follow the 1-cycle latency and counts match a reference model.

Source files
------------

// File: rtl/io_responder_pkg.sv
// ============================================================================
//  Module      : io_responder_pkg
//  Description : Shared handshake state encodings and default sizes for the
//                programmed-I/O responder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package io_responder_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_ACK  = 1'b1;

    localparam int DEF_WIDTH = 16;
    localparam int DEF_DEPTH = 4;

endpackage

`default_nettype wire

// File: rtl/io_responder_sync_fifo.sv
// ============================================================================
//  Module      : sync_fifo
//  Description : Show-ahead synchronous FIFO with occupancy count; no bypass.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module sync_fifo #(
    parameter  int WIDTH = 16,
    parameter  int DEPTH = 4,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    // Full/empty come from the registered count only, so a word written this
    // cycle is never visible to a pop before the next cycle.
    assign full      = (r_count == CW'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_data = r_mem[r_rd_ptr];
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/io_responder.sv
// ============================================================================
//  Module      : io_responder
//  Description : Device side of the CPU four-phase programmed-I/O handshake,
//                backed by an RX FIFO (CPU input) and a TX FIFO (CPU output).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module io_responder
    import io_responder_pkg::*;
#(
    parameter  int WIDTH = DEF_WIDTH,
    parameter  int DEPTH = DEF_DEPTH,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inp_req,
    output logic             inp_ack,
    output logic [WIDTH-1:0] inp_data,
    input  logic             out_req,
    input  logic [WIDTH-1:0] out_data,
    output logic             out_ack,
    input  logic             rx_valid,
    input  logic [WIDTH-1:0] rx_data,
    output logic             rx_ready,
    output logic             tx_valid,
    output logic [WIDTH-1:0] tx_data,
    input  logic             tx_ready,
    output logic [CW-1:0]    rx_count,
    output logic [CW-1:0]    tx_count
);

    logic             r_inp_state;
    logic             w_inp_state_nxt;
    logic             r_out_state;
    logic             w_out_state_nxt;
    logic [WIDTH-1:0] r_inp_data;
    logic [WIDTH-1:0] w_rx_head;
    logic             w_rx_full;
    logic             w_rx_empty;
    logic             w_rx_pop;
    logic             w_tx_full;
    logic             w_tx_empty;
    logic             w_tx_push;

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (rx_valid && rx_ready),
        .push_data (rx_data),
        .pop       (w_rx_pop),
        .head_data (w_rx_head),
        .full      (w_rx_full),
        .empty     (w_rx_empty),
        .count     (rx_count)
    );

    sync_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (w_tx_push),
        .push_data (out_data),
        .pop       (tx_valid && tx_ready),
        .head_data (tx_data),
        .full      (w_tx_full),
        .empty     (w_tx_empty),
        .count     (tx_count)
    );

    assign rx_ready = !w_rx_full;
    assign tx_valid = !w_tx_empty;
    assign inp_ack  = (r_inp_state == ST_ACK);
    assign out_ack  = (r_out_state == ST_ACK);
    assign inp_data = r_inp_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_inp_state <= ST_IDLE;
            r_out_state <= ST_IDLE;
            r_inp_data  <= '0;
        end else begin
            r_inp_state <= w_inp_state_nxt;
            r_out_state <= w_out_state_nxt;
            if (w_rx_pop) begin
                r_inp_data <= w_rx_head;
            end
        end
    end

    // Each FSM pops/pushes exactly once, on the IDLE->ACK transition.
    always_comb begin
        w_inp_state_nxt = r_inp_state;
        w_rx_pop        = 1'b0;
        if (r_inp_state == ST_IDLE) begin
            if (inp_req && !w_rx_empty) begin
                w_rx_pop        = 1'b1;
                w_inp_state_nxt = ST_ACK;
            end
        end else if (!inp_req) begin
            w_inp_state_nxt = ST_IDLE;
        end
    end

    always_comb begin
        w_out_state_nxt = r_out_state;
        w_tx_push       = 1'b0;
        if (r_out_state == ST_IDLE) begin
            if (out_req && !w_tx_full) begin
                w_tx_push       = 1'b1;
                w_out_state_nxt = ST_ACK;
            end
        end else if (!out_req) begin
            w_out_state_nxt = ST_IDLE;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_io_responder.sv
// ============================================================================
//  Module      : tb_io_responder
//  Description : Directed, table-driven bench for io_responder.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_io_responder;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int NVEC  = 14;

    logic             clk = 1'b0;
    logic             rst;
    logic             inp_req;
    logic             inp_ack;
    logic [WIDTH-1:0] inp_data;
    logic             out_req;
    logic [WIDTH-1:0] out_data;
    logic             out_ack;
    logic             rx_valid;
    logic [WIDTH-1:0] rx_data;
    logic             rx_ready;
    logic             tx_valid;
    logic [WIDTH-1:0] tx_data;
    logic             tx_ready;
    logic [CW-1:0]    rx_count;
    logic [CW-1:0]    tx_count;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic             inp_req;
        logic             out_req;
        logic [WIDTH-1:0] out_data;
        logic             rx_valid;
        logic [WIDTH-1:0] rx_data;
        logic             tx_ready;
        logic             exp_inp_ack;
        logic [WIDTH-1:0] exp_inp_data;
        logic             exp_out_ack;
        logic [CW-1:0]    exp_rx_count;
        logic [CW-1:0]    exp_tx_count;
        logic             exp_tx_valid;
        logic [WIDTH-1:0] exp_tx_data;
    } vec_t;

    vec_t vecs [NVEC];

    io_responder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .inp_req  (inp_req),
        .inp_ack  (inp_ack),
        .inp_data (inp_data),
        .out_req  (out_req),
        .out_data (out_data),
        .out_ack  (out_ack),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ready (rx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .rx_count (rx_count),
        .tx_count (tx_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_inp_ack(input logic lvl, input int bound, input string name);
        int n = 0;
        while (inp_ack !== lvl && n < bound) begin
            step();
            n++;
        end
        chk(name, 32'(inp_ack), 32'(lvl));
    endtask

    initial begin
        // inp_req, out_req, out_data, rx_valid, rx_data, tx_ready,
        // exp: inp_ack, inp_data, out_ack, rx_count, tx_count, tx_valid, tx_data
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd1, 3'd0, 1'b0, 16'h0000};
        vecs[1]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hA5A5, 1'b0, 3'd0, 3'd0, 1'b0, 16'h0000};
        vecs[2]  = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'hA5A5, 1'b0, 3'd0, 3'd0, 1'b0, 16'h0000};
        vecs[3]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hA5A5, 1'b0, 3'd0, 3'd0, 1'b0, 16'h0000};
        vecs[4]  = '{1'b0, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hA5A5, 1'b1, 3'd0, 3'd1, 1'b1, 16'h1234};
        vecs[5]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'hA5A5, 1'b0, 3'd0, 3'd1, 1'b1, 16'h1234};
        vecs[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h1111, 1'b0, 1'b0, 16'hA5A5, 1'b0, 3'd1, 3'd1, 1'b1, 16'h1234};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h2222, 1'b0, 1'b0, 16'hA5A5, 1'b0, 3'd2, 3'd1, 1'b1, 16'h1234};
        vecs[8]  = '{1'b1, 1'b1, 16'h5678, 1'b1, 16'h3333, 1'b1, 1'b1, 16'h1111, 1'b1, 3'd2, 3'd1, 1'b1, 16'h5678};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h1111, 1'b0, 3'd2, 3'd1, 1'b1, 16'h5678};
        vecs[10] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h2222, 1'b0, 3'd1, 3'd1, 1'b1, 16'h5678};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h2222, 1'b0, 3'd1, 3'd1, 1'b1, 16'h5678};
        vecs[12] = '{1'b1, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 16'h3333, 1'b0, 3'd0, 3'd1, 1'b1, 16'h5678};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h3333, 1'b0, 3'd0, 3'd0, 1'b0, 16'h0000};

        rst = 1'b1;
        inp_req = 1'b0; out_req = 1'b0; out_data = '0;
        rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset inp_ack", 32'(inp_ack), 0);
        chk("reset out_ack", 32'(out_ack), 0);
        chk("reset inp_data", 32'(inp_data), 0);
        chk("reset rx_count", 32'(rx_count), 0);
        chk("reset tx_count", 32'(tx_count), 0);
        chk("reset tx_valid", 32'(tx_valid), 0);
        chk("reset rx_ready", 32'(rx_ready), 1);
        @(negedge clk);
        rst = 1'b0;
        step();

        // Table: basic input/output handshakes and a concurrent push/pop cycle
        for (int i = 0; i < NVEC; i++) begin
            inp_req  = vecs[i].inp_req;
            out_req  = vecs[i].out_req;
            out_data = vecs[i].out_data;
            rx_valid = vecs[i].rx_valid;
            rx_data  = vecs[i].rx_data;
            tx_ready = vecs[i].tx_ready;
            step();
            chk($sformatf("vec%0d inp_ack", i), 32'(inp_ack), 32'(vecs[i].exp_inp_ack));
            chk($sformatf("vec%0d inp_data", i), 32'(inp_data), 32'(vecs[i].exp_inp_data));
            chk($sformatf("vec%0d out_ack", i), 32'(out_ack), 32'(vecs[i].exp_out_ack));
            chk($sformatf("vec%0d rx_count", i), 32'(rx_count), 32'(vecs[i].exp_rx_count));
            chk($sformatf("vec%0d tx_count", i), 32'(tx_count), 32'(vecs[i].exp_tx_count));
            chk($sformatf("vec%0d tx_valid", i), 32'(tx_valid), 32'(vecs[i].exp_tx_valid));
            chk($sformatf("vec%0d rx_ready", i), 32'(rx_ready), 32'(vecs[i].exp_rx_count != 3'(DEPTH)));
            if (vecs[i].exp_tx_valid) begin
                chk($sformatf("vec%0d tx_data", i), 32'(tx_data), 32'(vecs[i].exp_tx_data));
            end
        end
        inp_req = 1'b0; out_req = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;

        // Input request against an empty RX FIFO, then a late word (no bypass)
        inp_req = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            chk($sformatf("stall%0d inp_ack", i), 32'(inp_ack), 0);
        end
        rx_valid = 1'b1; rx_data = 16'h0042;
        step();
        rx_valid = 1'b0;
        chk("late push inp_ack", 32'(inp_ack), 0);
        chk("late push rx_count", 32'(rx_count), 1);
        step();
        chk("late inp_ack", 32'(inp_ack), 1);
        chk("late inp_data", 32'(inp_data), 16'h0042);
        chk("late rx_count", 32'(rx_count), 0);
        inp_req = 1'b0;
        step();
        chk("late drop inp_ack", 32'(inp_ack), 0);

        // Output into a full TX FIFO
        tx_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            out_req = 1'b1; out_data = 16'(i);
            step();
            chk($sformatf("fill%0d out_ack", i), 32'(out_ack), 1);
            out_req = 1'b0;
            step();
            chk($sformatf("fill%0d out_ack low", i), 32'(out_ack), 0);
        end
        chk("full tx_count", 32'(tx_count), 4);
        out_req = 1'b1; out_data = 16'h0005;
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("full stall%0d out_ack", i), 32'(out_ack), 0);
        end
        chk("full head tx_data", 32'(tx_data), 16'h0001);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        chk("full pop out_ack", 32'(out_ack), 0);
        chk("full pop tx_count", 32'(tx_count), 3);
        step();
        chk("fifth out_ack", 32'(out_ack), 1);
        chk("fifth tx_count", 32'(tx_count), 4);
        out_req = 1'b0;
        step();
        chk("fifth out_ack low", 32'(out_ack), 0);
        for (int i = 2; i <= 5; i++) begin
            chk($sformatf("drain%0d tx_data", i), 32'(tx_data), 32'(i));
            tx_ready = 1'b1;
            step();
            tx_ready = 1'b0;
        end
        chk("drain tx_valid", 32'(tx_valid), 0);

        // Ten words through RX with interleaved reads; pointers wrap twice
        begin
            int p;
            p = 0;
            for (int i = 0; i < 3; i++) begin
                rx_valid = 1'b1; rx_data = 16'h0100 + 16'(p); p++;
                step();
            end
            rx_valid = 1'b0;
            chk("wrap prefill rx_count", 32'(rx_count), 3);
            for (int r = 0; r < 10; r++) begin
                inp_req = 1'b1;
                if (p < 10) begin
                    rx_valid = 1'b1; rx_data = 16'h0100 + 16'(p); p++;
                end
                step();
                rx_valid = 1'b0;
                wait_inp_ack(1'b1, 20, $sformatf("wrap%0d ack", r));
                chk($sformatf("wrap%0d inp_data", r), 32'(inp_data), 32'(16'h0100 + 16'(r)));
                inp_req = 1'b0;
                wait_inp_ack(1'b0, 20, $sformatf("wrap%0d ack low", r));
            end
            chk("wrap end rx_count", 32'(rx_count), 0);
        end

        // Asynchronous reset in the middle of both handshakes
        rx_valid = 1'b1; rx_data = 16'hB001;
        step();
        rx_data = 16'hB002;
        step();
        rx_valid = 1'b0;
        inp_req = 1'b1; out_req = 1'b1; out_data = 16'hC0DE;
        step();
        chk("pre-rst inp_ack", 32'(inp_ack), 1);
        chk("pre-rst inp_data", 32'(inp_data), 16'hB001);
        chk("pre-rst out_ack", 32'(out_ack), 1);
        #3;
        rst = 1'b1;
        #1;
        chk("async rst inp_ack", 32'(inp_ack), 0);
        chk("async rst out_ack", 32'(out_ack), 0);
        chk("async rst inp_data", 32'(inp_data), 0);
        chk("async rst rx_count", 32'(rx_count), 0);
        chk("async rst tx_count", 32'(tx_count), 0);
        chk("async rst rx_ready", 32'(rx_ready), 1);
        chk("async rst tx_valid", 32'(tx_valid), 0);
        inp_req = 1'b0; out_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        chk("post-rst inp_ack", 32'(inp_ack), 0);
        chk("post-rst out_ack", 32'(out_ack), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
